// File: rtl/coincidence_sequencer.sv
// coincidence_sequencer
// Front-end sequencer for the MPPC channel pads. After reset it holds every pad
// in discharge for DISCHARGE_CYCLES cycles. It then arms and watches synchronized
// rising edges on the masked channels. A window opens on the first edge and lasts
// WINDOW cycles. If enough channels fired within the window, one event is offered
// on a single-entry valid/ready output register, followed by DEADTIME cycles in
// which edges are ignored.
// Optional feature: define COINC_TIMESTAMP_EN to get a free-running timestamp
// counter and a window-open timestamp on evt_ts; otherwise evt_ts is tied to 0.
module coincidence_sequencer #(
    parameter int NCH              = 8,
    parameter int DISCHARGE_CYCLES = 65536,
    parameter int WINDOW           = 8,
    parameter int DEADTIME         = 64,
    parameter int TS_W             = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NCH-1:0]  ch_in,
    output logic [NCH-1:0]  discharge_oe,
    input  logic            enable,
    input  logic [NCH-1:0]  mask,
    input  logic [3:0]      min_hits,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [NCH-1:0]  evt_hits,
    output logic [TS_W-1:0] evt_ts,
    output logic [15:0]     drop_cnt,
    output logic [1:0]      state
);

    localparam logic [1:0] S_DISCHARGE = 2'd0;
    localparam logic [1:0] S_ARMED     = 2'd1;
    localparam logic [1:0] S_WINDOW    = 2'd2;
    localparam logic [1:0] S_DEAD      = 2'd3;

    localparam int DIS_W  = $clog2(DISCHARGE_CYCLES + 1);
    localparam int WIN_W  = $clog2(WINDOW + 1);
    localparam int DEAD_W = $clog2(DEADTIME + 1);

    localparam logic [DIS_W-1:0]  DIS_LAST  = DIS_W'(DISCHARGE_CYCLES - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME - 1);

    // Channel input pipeline
    logic [NCH-1:0] r_sync1;
    logic [NCH-1:0] r_sync2;
    logic [NCH-1:0] r_sync3;
    logic [NCH-1:0] r_edge;

    // Sequencer state
    logic [1:0]        r_state;
    logic [NCH-1:0]    r_oe;
    logic [DIS_W-1:0]  r_dis_cnt;
    logic [WIN_W-1:0]  r_win_cnt;
    logic [DEAD_W-1:0] r_dead_cnt;
    logic [NCH-1:0]    r_hits;
    logic [NCH-1:0]    r_mask;
    logic [3:0]        r_min_hits;

    // Output register
    logic           r_evt_valid;
    logic [NCH-1:0] r_evt_hits;
    logic [15:0]    r_drop_cnt;

    // Window decode
    logic           w_open;
    logic           w_eval;
    logic           w_pass;
    logic           w_load;
    logic [NCH-1:0] w_eval_hits;
    logic [3:0]     w_eval_min;
    logic [3:0]     w_min_eff;

    // Two-flop synchronizer plus registered rising-edge detect; runs in every state
    always_ff @(posedge CLK) begin
        // NOTE: all clocked state uses non-blocking assignments so every flop
        // samples the pre-edge values of its neighbours, as real hardware does.
        if (RST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
            r_edge  <= '0;
        end else begin
            r_sync1 <= ch_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_edge  <= r_sync2 & ~r_sync3;
        end
    end

    // Decide whether a window opens or closes this cycle and whether it qualifies
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // skipped an assignment would otherwise infer a latch.
        w_open      = 1'b0;
        w_eval      = 1'b0;
        w_eval_hits = r_hits | (r_edge & r_mask);
        w_eval_min  = r_min_hits;
        case (r_state)
            S_ARMED: begin
                // The opening cycle counts as the first window cycle, so a
                // one-cycle window is judged right here on the opening edges.
                w_open      = enable && (|(r_edge & mask));
                w_eval_hits = r_edge & mask;
                w_eval_min  = min_hits;
                w_eval      = w_open && (WINDOW == 1);
            end
            S_WINDOW: begin
                w_eval = enable && (r_win_cnt == WIN_LAST);
            end
            default: begin
            end
        endcase
        w_min_eff = (w_eval_min == 4'd0) ? 4'd1 : w_eval_min;
        w_pass    = w_eval && ($countones(w_eval_hits) >= int'(w_min_eff));
        w_load    = w_pass && (!r_evt_valid || evt_ready);
    end

    // Discharge / armed / window / dead sequencing
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_DISCHARGE;
            r_oe       <= '1;
            r_dis_cnt  <= '0;
            r_win_cnt  <= '0;
            r_dead_cnt <= '0;
            r_hits     <= '0;
            r_mask     <= '0;
            r_min_hits <= '0;
        end else begin
            case (r_state)
                S_DISCHARGE: begin
                    if (r_dis_cnt == DIS_LAST) begin
                        r_oe    <= '0;
                        r_state <= S_ARMED;
                    end else begin
                        r_dis_cnt <= r_dis_cnt + 1'b1;
                    end
                end
                S_ARMED: begin
                    if (w_open) begin
                        // Mask and threshold are frozen for the whole window.
                        r_hits     <= r_edge & mask;
                        r_mask     <= mask;
                        r_min_hits <= min_hits;
                        r_win_cnt  <= WIN_W'(1);
                        r_dead_cnt <= '0;
                        if (WINDOW == 1) begin
                            r_state <= w_pass ? S_DEAD : S_ARMED;
                        end else begin
                            r_state <= S_WINDOW;
                        end
                    end
                end
                S_WINDOW: begin
                    if (!enable) begin
                        r_state <= S_ARMED;
                    end else if (w_eval) begin
                        r_dead_cnt <= '0;
                        r_state    <= w_pass ? S_DEAD : S_ARMED;
                    end else begin
                        r_hits    <= w_eval_hits;
                        r_win_cnt <= r_win_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_dead_cnt == DEAD_LAST) begin
                        r_state <= S_ARMED;
                    end else begin
                        r_dead_cnt <= r_dead_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Single-entry event register with saturating drop counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_evt_valid <= 1'b0;
            r_evt_hits  <= '0;
            r_drop_cnt  <= '0;
        end else if (w_pass) begin
            if (w_load) begin
                r_evt_valid <= 1'b1;
                r_evt_hits  <= w_eval_hits;
            end else if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end else if (r_evt_valid && evt_ready) begin
            r_evt_valid <= 1'b0;
        end
    end

`ifdef COINC_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_win_ts;
    logic [TS_W-1:0] r_evt_ts;
    logic [TS_W-1:0] w_eval_ts;

    // A one-cycle window is judged in the opening cycle, before r_win_ts is captured.
    assign w_eval_ts = (r_state == S_ARMED) ? r_ts : r_win_ts;

    // Free-running timestamp, capture at window open, copy into the event payload
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ts     <= '0;
            r_win_ts <= '0;
            r_evt_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
            if (w_open) begin
                r_win_ts <= r_ts;
            end
            if (w_load) begin
                r_evt_ts <= w_eval_ts;
            end
        end
    end

    assign evt_ts = r_evt_ts;
`else
    assign evt_ts = '0;
`endif

    assign discharge_oe = r_oe;
    assign evt_valid    = r_evt_valid;
    assign evt_hits     = r_evt_hits;
    assign drop_cnt     = r_drop_cnt;
    assign state        = r_state;

endmodule

// File: tb/tb_coincidence_sequencer.sv
// tb_coincidence_sequencer
// Directed scenarios plus a randomized run. A time-based reference model predicts
// every output after each clock edge; a compare process checks them on every
// falling edge. Literal expectations pin key moments of the directed scenarios.
module tb_coincidence_sequencer;

    localparam int NCH  = 8;
    localparam int DIS  = 16;
    localparam int WIN  = 8;
    localparam int DEAD = 12;
    localparam int TSW  = 4;

    logic            CLK = 1'b0;
    logic            RST;
    logic [NCH-1:0]  ch_in;
    logic [NCH-1:0]  discharge_oe;
    logic            enable;
    logic [NCH-1:0]  mask;
    logic [3:0]      min_hits;
    logic            evt_valid;
    logic            evt_ready;
    logic [NCH-1:0]  evt_hits;
    logic [TSW-1:0]  evt_ts;
    logic [15:0]     drop_cnt;
    logic [1:0]      state;

    coincidence_sequencer #(
        .NCH(NCH), .DISCHARGE_CYCLES(DIS), .WINDOW(WIN), .DEADTIME(DEAD), .TS_W(TSW)
    ) dut (
        .CLK(CLK), .RST(RST), .ch_in(ch_in), .discharge_oe(discharge_oe),
        .enable(enable), .mask(mask), .min_hits(min_hits),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_hits(evt_hits),
        .evt_ts(evt_ts), .drop_cnt(drop_cnt), .state(state)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Time is counted in clock edges since reset (k). An edge on a pad sampled at
    // edge j is acted on at edge j+3. The sequencer is busy (ignoring edges)
    // through edge m_busy; windows are described by their opening time.
    bit             m_init = 1'b0;
    int             g      = 0;
    int             k      = 0;
    int             m_busy = DIS;
    logic [NCH-1:0] samp [8] = '{default: '0};
    bit             win_open = 1'b0;
    int             w_t0;
    logic [NCH-1:0] w_hits, w_mask;
    logic [3:0]     w_min;
    logic [TSW-1:0] w_ts;
    bit             m_valid = 1'b0;
    logic [NCH-1:0] m_hits  = '0;
    logic [TSW-1:0] m_ts    = '0;
    int             m_drop  = 0;

    function automatic bit qualifies(input logic [NCH-1:0] h, input logic [3:0] m);
        int need;
        need = (m == 4'd0) ? 1 : int'(m);
        return $countones(h) >= need;
    endfunction

    always @(posedge CLK) begin
        logic [NCH-1:0] e;
        bit deliver;
        samp[g % 8] = ch_in;
        e = samp[(g + 5) % 8] & ~samp[(g + 4) % 8];
        g++;
        if (RST) begin
            m_init   = 1'b1;
            k        = 0;
            m_busy   = DIS;
            win_open = 1'b0;
            m_valid  = 1'b0;
            m_hits   = '0;
            m_ts     = '0;
            m_drop   = 0;
        end else begin
            k++;
            deliver = 1'b0;
            if (win_open) begin
                if (!enable) begin
                    win_open = 1'b0;
                    m_busy   = k;
                end else begin
                    w_hits |= e & w_mask;
                    if (k == w_t0 + WIN - 1) begin
                        win_open = 1'b0;
                        deliver  = qualifies(w_hits, w_min);
                        m_busy   = deliver ? k + DEAD : k;
                    end
                end
            end else if (k > m_busy && enable && (|(e & mask))) begin
                w_t0   = k;
                w_hits = e & mask;
                w_mask = mask;
                w_min  = min_hits;
                w_ts   = TSW'(k - 1);
                if (WIN == 1) begin
                    deliver = qualifies(w_hits, w_min);
                    m_busy  = deliver ? k + DEAD : k;
                end else begin
                    win_open = 1'b1;
                end
            end
            if (deliver) begin
                if (!m_valid || evt_ready) begin
                    m_valid = 1'b1;
                    m_hits  = w_hits;
                    m_ts    = w_ts;
                end else if (m_drop < 16'hFFFF) begin
                    m_drop++;
                end
            end else if (m_valid && evt_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare every DUT output with the model once per cycle
    always @(negedge CLK) begin
        logic [1:0]     exp_state;
        logic [TSW-1:0] exp_ts;
        if (m_init) begin
            if (k < DIS)          exp_state = 2'd0;
            else if (win_open)    exp_state = 2'd2;
            else if (k < m_busy)  exp_state = 2'd3;
            else                  exp_state = 2'd1;
`ifdef COINC_TIMESTAMP_EN
            exp_ts = m_ts;
`else
            exp_ts = '0;
`endif
            check("state", state, exp_state);
            check("discharge_oe", discharge_oe, (k < DIS) ? {NCH{1'b1}} : {NCH{1'b0}});
            check("evt_valid", evt_valid, m_valid);
            check("evt_hits", evt_hits, m_hits);
            check("evt_ts", evt_ts, exp_ts);
            check("drop_cnt", drop_cnt, 16'(m_drop));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Bounded wait for a state value; returns just after the following rising edge.
    task automatic wait_for_state(input logic [1:0] s, input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge CLK);
            if (state == s) seen = 1'b1;
        end
        check(name, seen, 1'b1);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0] flip;
        RST = 1'b1; ch_in = '0; enable = 1'b1; mask = 8'h03; min_hits = 4'd2; evt_ready = 1'b0;
        tick(3);
        RST = 1'b0;

        // Reset values, then discharge timing
        @(negedge CLK);
        check("reset_oe", discharge_oe, 8'hFF);
        check("reset_state", state, 2'd0);
        check("reset_valid", evt_valid, 1'b0);
        check("reset_drop", drop_cnt, 16'd0);
        repeat (15) @(posedge CLK);
        @(negedge CLK);
        check("dis_oe_last", discharge_oe, 8'hFF);
        @(negedge CLK);
        check("dis_oe_off", discharge_oe, 8'h00);
        check("dis_armed", state, 2'd1);
        @(posedge CLK); #1;

        // CH0 then CH1 five cycles later: one event
        ch_in = 8'h01; tick(5);
        ch_in = 8'h03;
        wait_for_state(2'd3, 30, "coinc_dead_wait");
        check("coinc_valid", evt_valid, 1'b1);
        check("coinc_hits", evt_hits, 8'h03);
`ifdef COINC_TIMESTAMP_EN
        check("coinc_ts", evt_ts, 4'd4);
`else
        check("coinc_ts", evt_ts, 4'd0);
`endif
        evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
        ch_in = 8'h00; tick(DEAD + 5);
        @(negedge CLK);
        check("rearmed", state, 2'd1);
        @(posedge CLK); #1;

        // CH1 eight cycles after CH0: outside the window, no event
        ch_in = 8'h01; tick(8);
        ch_in = 8'h03; tick(25);
        @(negedge CLK);
        check("late_state", state, 2'd1);
        check("late_valid", evt_valid, 1'b0);
        @(posedge CLK); #1;
        ch_in = 8'h00; tick(5);

        // Three passing coincidences with the consumer stalled
        for (int i = 0; i < 3; i++) begin
            ch_in = 8'h03; tick(3);
            ch_in = 8'h00; tick(WIN + DEAD + 8);
        end
        @(negedge CLK);
        check("stall_drop", drop_cnt, 16'd2);
        check("stall_valid", evt_valid, 1'b1);
        check("stall_hits", evt_hits, 8'h03);
        @(posedge CLK); #1;
        evt_ready = 1'b1; tick(2);
        @(negedge CLK);
        check("stall_drained", evt_valid, 1'b0);
        @(posedge CLK); #1;

        // min_hits=0 on a single masked channel, consumer always ready
        mask = 8'h01; min_hits = 4'd0;
        ch_in = 8'h01; tick(3);
        ch_in = 8'h00; tick(25);
        check("single_nodrop", drop_cnt, 16'd2);

        // Reload: accept the held event in the cycle a new one qualifies
        evt_ready = 1'b0;
        ch_in = 8'h01; tick(3);
        ch_in = 8'h00; tick(25);
        ch_in = 8'h01;
        wait_for_state(2'd2, 10, "reload_open_wait");
        tick(5);
        evt_ready = 1'b1;
        @(negedge CLK);
        check("reload_valid", evt_valid, 1'b1);
        check("reload_nodrop", drop_cnt, 16'd2);
        @(posedge CLK); #1;
        ch_in = 8'h00; tick(25);

        // min_hits=9 with all channels firing: never qualifies
        evt_ready = 1'b0; mask = 8'hFF; min_hits = 4'd9;
        ch_in = 8'hFF; tick(3);
        ch_in = 8'h00; tick(20);
        @(negedge CLK);
        check("min9_valid", evt_valid, 1'b0);
        check("min9_state", state, 2'd1);
        @(posedge CLK); #1;

        // enable dropped mid-window
        mask = 8'h03; min_hits = 4'd2;
        ch_in = 8'h01; tick(2);
        ch_in = 8'h03;
        wait_for_state(2'd2, 10, "abort_open_wait");
        enable = 1'b0; tick(2);
        enable = 1'b1; ch_in = 8'h00; tick(20);
        @(negedge CLK);
        check("abort_valid", evt_valid, 1'b0);
        check("abort_state", state, 2'd1);
        @(posedge CLK); #1;

        // Reset mid-window with an event pending
        ch_in = 8'h03; tick(3);
        ch_in = 8'h00; tick(25);
        check("pre_rst_valid", evt_valid, 1'b1);
        ch_in = 8'h01;
        wait_for_state(2'd2, 10, "rst_open_wait");
        RST = 1'b1; ch_in = 8'h00; tick(2);
        @(negedge CLK);
        check("rst_valid", evt_valid, 1'b0);
        check("rst_oe", discharge_oe, 8'hFF);
        check("rst_state", state, 2'd0);
        check("rst_drop", drop_cnt, 16'd0);
        @(posedge CLK); #1;
        RST = 1'b0; tick(DIS + 5);

        // Randomized run
        for (int c = 0; c < 3000; c++) begin
            RST = ($urandom_range(0, 799) == 0);
            for (int b = 0; b < NCH; b++) flip[b] = ($urandom_range(0, 5) == 0);
            ch_in     = ch_in ^ flip;
            enable    = ($urandom_range(0, 19) != 0);
            evt_ready = ($urandom_range(0, 2) != 0);
            if (c % 50 == 0) begin
                mask     = NCH'($urandom);
                min_hits = 4'($urandom_range(0, 9));
            end
            tick(1);
        end
        RST = 1'b0; ch_in = '0; tick(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
